// File: rtl/delay_timer_arbiter_pkg.sv
// Shared definitions for the paint-controller delay timer arbiter:
// FSM state encodings, default counter width and named terminal counts.
package delay_timer_arbiter_pkg;

  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Cursor blink period and button hold time, in timer ticks.
  localparam logic [CNT_W_DEF-1:0] TC_BLINK = 24'd5_000_000;
  localparam logic [CNT_W_DEF-1:0] TC_HOLD  = 24'd1_000_000;

endpackage

// File: rtl/delay_timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req set,
// scanning last+1, last+2, ... modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  // Scan from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    int j;
    j        = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(last_i) + k) % N_REQ;
      if (req_i[j]) begin
        winner_o = IDX_W'(j);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shares one up-counter among N_REQ requesting FSMs. Each grant runs the
// counter from 0 to the winner's latched terminal count, then emits a
// one-cycle done pulse. Dropping req mid-count aborts without a pulse.
module delay_timer_arbiter
  import delay_timer_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] tc_flat_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       cnt_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tc_lat_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;

  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic [N_REQ-1:0] win_oh;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .winner_o(win_idx),
    .valid_o (win_vld)
  );

  assign win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  // Arbitration / count FSM; everything advances on the falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tc_lat_q <= '0;
      idx_q    <= '0;
      last_q   <= IDX_W'(N_REQ-1);
      grant_q  <= '0;
      done_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            idx_q    <= win_idx;
            tc_lat_q <= tc_flat_i[win_idx*CNT_W +: CNT_W];
            cnt_q    <= '0;
            grant_q  <= win_oh;
            state_q  <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Abort wins over a terminal match on the same edge.
          if (!req_i[idx_q]) begin
            grant_q <= '0;
            last_q  <= idx_q;
            state_q <= ST_IDLE;
          end else if (cnt_q == tc_lat_q) begin
            grant_q <= '0;
            done_q  <= grant_q;
            last_q  <= idx_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          grant_q <= '0;
          done_q  <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign cnt_o   = cnt_q;

endmodule
